// File: rtl/bit_gather.sv
// Serial-to-parallel gather: collects a bit-serial stream into WIDTH-bit words.
// One capture flop per lane; the completing bit bypasses its flop straight into word_o.
module bit_gather_lane (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic we_i,
   input  logic d_i,
   output logic q_o
);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   q_o <= 1'b0;
      else if (we_i) q_o <= d_i;
   end
endmodule

module bit_gather #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 0
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     bit_valid_i,
   input  logic                     bit_i,
   output logic                     bit_ready_o,
   input  logic                     flush_i,
   output logic                     word_valid_o,
   output logic [WIDTH-1:0]         word_o,
   input  logic                     word_ready_i,
   output logic [$clog2(WIDTH)-1:0] count_o
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] lane_sel;
   logic [WIDTH-1:0] lane_q;
   logic [WIDTH-1:0] word_next;
   logic             last;
   logic             accept;
   logic             complete;
   logic             xfer;

   assign last        = (count_q == LAST);
   // Only the completing bit has to wait for the held word to drain.
   assign bit_ready_o = !(last && word_valid_o && !word_ready_i);
   assign accept      = bit_valid_i && bit_ready_o && !flush_i;
   assign complete    = accept && last;
   assign xfer        = word_valid_o && word_ready_i;
   assign count_o     = count_q;

   for (genvar j = 0; j < WIDTH; j++) begin : g_lane
      localparam int SLOT = (MSB_FIRST != 0) ? (WIDTH - 1 - j) : j;
      assign lane_sel[j] = (count_q == CW'(SLOT));
      bit_gather_lane u_lane (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .we_i   (accept && lane_sel[j]),
         .d_i    (bit_i),
         .q_o    (lane_q[j])
      );
      assign word_next[j] = lane_sel[j] ? bit_i : lane_q[j];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (flush_i) begin
         count_q <= '0;
      end else if (accept) begin
         count_q <= last ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_valid_o <= 1'b0;
         word_o       <= '0;
      end else if (complete) begin
         word_valid_o <= 1'b1;
         word_o       <= word_next;
      end else if (xfer) begin
         word_valid_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bit_gather.sv
// Directed bench for bit_gather: LSB-first and MSB-first instances share one stream,
// checked every cycle against a queue-based model plus literal spot checks.
module tb_bit_gather;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bit_valid = 1'b0, bit_in = 1'b0, flush = 1'b0, word_ready = 1'b0;
   logic rdy0, vld0, rdy1, vld1;
   logic [W-1:0] word0, word1;
   logic [1:0] cnt0, cnt1;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bit_gather #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
      .clk_i(clk), .rst_ni(rst_n), .bit_valid_i(bit_valid), .bit_i(bit_in),
      .bit_ready_o(rdy0), .flush_i(flush), .word_valid_o(vld0), .word_o(word0),
      .word_ready_i(word_ready), .count_o(cnt0));

   bit_gather #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
      .clk_i(clk), .rst_ni(rst_n), .bit_valid_i(bit_valid), .bit_i(bit_in),
      .bit_ready_o(rdy1), .flush_i(flush), .word_valid_o(vld1), .word_o(word1),
      .word_ready_i(word_ready), .count_o(cnt1));

   // model: the bits of the partial word in arrival order, plus the presented word
   bit       mq[$];
   bit       m_vld = 1'b0;
   bit [W-1:0] m_lsb = '0, m_msb = '0;

   function automatic bit m_ready();
      return !(mq.size() == W - 1 && m_vld && !word_ready);
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_vld = 1'b0;
            m_lsb = '0;
            m_msb = '0;
         end else begin
            bit rdy, xf, done;
            rdy  = m_ready();
            xf   = m_vld && word_ready;
            done = 1'b0;
            if (flush) begin
               mq.delete();
            end else if (bit_valid && rdy) begin
               mq.push_back(bit_in);
               if (mq.size() == W) begin
                  for (int i = 0; i < W; i++) begin
                     m_lsb[i]         = mq[i];
                     m_msb[W - 1 - i] = mq[i];
                  end
                  mq.delete();
                  done = 1'b1;
               end
            end
            if (done)    m_vld = 1'b1;
            else if (xf) m_vld = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("lsb_vld", 32'(vld0), 32'(m_vld));
            chk("msb_vld", 32'(vld1), 32'(m_vld));
            chk("lsb_cnt", 32'(cnt0), 32'(mq.size()));
            chk("msb_cnt", 32'(cnt1), 32'(mq.size()));
            chk("lsb_rdy", 32'(rdy0), 32'(m_ready()));
            chk("msb_rdy", 32'(rdy1), 32'(m_ready()));
            if (m_vld) begin
               chk("lsb_word", 32'(word0), 32'(m_lsb));
               chk("msb_word", 32'(word1), 32'(m_msb));
            end
         end
      end
   end

   task automatic drive(input logic v, input logic b, input logic r, input logic f);
      bit_valid  = v;
      bit_in     = b;
      word_ready = r;
      flush      = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic b, input logic r);
      drive(1'b1, b, r, 1'b0);
      tick();
   endtask

   initial begin
      logic [15:0] pat;
      logic [3:0]  s4;
      int          nv;

      // reset state, checked while reset is held
      #2;
      chk("rst_vld", 32'(vld0), 32'd0);
      chk("rst_word", 32'(word0), 32'd0);
      chk("rst_cnt", 32'(cnt0), 32'd0);
      chk("rst_rdy", 32'(rdy0), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();

      // single word 1,0,1,1
      s4 = 4'b1101;
      for (int i = 0; i < 4; i++) send(s4[i], 1'b1);
      chk("single_vld", 32'(vld0), 32'd1);
      chk("single_lsb", 32'(word0), 32'h0000000D);
      chk("single_msb", 32'(word1), 32'h0000000B);
      chk("model_lsb", 32'(m_lsb), 32'h0000000D);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("single_onecyc", 32'(vld0), 32'd0);

      // back-pressure: F held, then 0,1,0 accepted, completing 1 stalls
      for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
      chk("bp_first", 32'(word0), 32'hF);
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      chk("bp_cnt3", 32'(cnt0), 32'd3);
      chk("bp_hold", 32'(word0), 32'hF);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      chk("bp_stall_rdy", 32'(rdy0), 32'd0);
      tick();
      chk("bp_still_held", 32'(word0), 32'hF);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      chk("bp_release_rdy", 32'(rdy0), 32'd1);
      tick();
      chk("bp_second_vld", 32'(vld0), 32'd1);
      chk("bp_second_lsb", 32'(word0), 32'hA);
      chk("bp_second_msb", 32'(word1), 32'h5);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();

      // continuous stream of 16 bits
      pat = 16'hC35A;
      nv = 0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, pat[i], 1'b1, 1'b0);
         #1;
         chk("cont_rdy", 32'(rdy0), 32'd1);
         tick();
         if (vld0) nv++;
         if (i == 15) chk("cont_last_word", 32'(word0), 32'hC);
      end
      chk("cont_words", 32'(nv), 32'd4);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();

      // flush drops the bit presented with it
      send(1'b1, 1'b1);
      send(1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      chk("flush_cnt", 32'(cnt0), 32'd0);
      s4 = 4'b0110;
      for (int i = 0; i < 4; i++) send(s4[i], 1'b0);
      chk("flush_lsb", 32'(word0), 32'h6);
      chk("flush_msb", 32'(word1), 32'h6);

      // completion + transfer + flush in one cycle: flush wins, transfer still clears
      for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      chk("fwin_vld", 32'(vld0), 32'd0);
      chk("fwin_cnt", 32'(cnt0), 32'd0);
      chk("fwin_word", 32'(word0), 32'h6);

      // reset mid-hold with a partial word
      s4 = 4'b1101;
      for (int i = 0; i < 4; i++) send(s4[i], 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      chk("pre_rst_cnt", 32'(cnt0), 32'd2);
      chk("pre_rst_vld", 32'(vld0), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_vld", 32'(vld0), 32'd0);
      chk("async_cnt", 32'(cnt0), 32'd0);
      chk("async_word", 32'(word0), 32'd0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      rst_n = 1'b1;
      s4 = 4'b1100;
      for (int i = 0; i < 4; i++) send(s4[i], 1'b1);
      chk("post_rst_lsb", 32'(word0), 32'hC);
      chk("post_rst_msb", 32'(word1), 32'h3);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bit_gather.md
# bit_gather

Serial-to-parallel gather block: accepts a bit-serial stream under a valid/ready handshake and assembles it into WIDTH-bit words, presented on a valid/ready output port. It is the collecting end of the per-bit lane fan-out used in the design. Upstream, a WIDTH-bit bus is split into one-bit lanes, each handled in its own generate scope. This block rebuilds the bus. Each lane j owns one capture flop, which is written only when the incoming bit index equals lane j. The block supports full throughput and back-pressure, and it can flush a partially collected word.

## Interface
Parameters:
- WIDTH, 4, word width and lane count; must be ≥ 2.
- MSB_FIRST, 0, bit order of the stream: 0 means the first accepted bit goes to lane 0; 1 means the first accepted bit goes to lane WIDTH-1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- bit_valid_i  input  1  serial bit present.
- bit_i  input  1  serial data bit.
- bit_ready_o  output  1  block can accept a bit this cycle.
- flush_i  input  1  synchronous discard of the partial word.
- word_valid_o  output  1  assembled word present.
- word_o  output  WIDTH  assembled word.
- word_ready_i  input  1  downstream accepts the word.
- count_o  output  $clog2(WIDTH)  number of bits collected into the current partial word.

## Operation
- Bit acceptance: a bit is accepted when bit_valid_i && bit_ready_o.
- Lane mapping: an accepted bit goes to lane L.
  - L = count when MSB_FIRST=0.
  - L = WIDTH-1-count when MSB_FIRST=1.
- Count update: count increments on each accepted bit and wraps to 0 after WIDTH-1.
- Word completion: the word completes when the accepted bit has count == WIDTH-1.
  - word_o loads the lane flops of lanes already captured, plus the current bit_i placed directly in its lane. No extra cycle is spent.
  - word_valid_o sets on the same edge.
- Output handshake: the word transfers when word_valid_o && word_ready_i.
  - On transfer with no new completion in the same cycle, word_valid_o clears. word_o holds its last value.
  - On transfer with a new completion in the same cycle, word_o reloads and word_valid_o stays 1.
- Back-pressure: bit_ready_o = !(count == WIDTH-1 && word_valid_o && !word_ready_i).
  - Bits 0..WIDTH-2 of the next word are accepted while the output is still held.
  - Only the completing bit stalls.
  - bit_ready_o depends combinationally on word_ready_i; upstream must not route bit_ready_o back into word_ready_i.
- Flush: flush_i high sets count to 0.
  - Any bit presented in the same cycle is dropped, even if valid and ready.
  - The output register and word_valid_o are unaffected.
  - bit_ready_o is still computed normally.
- Stale lanes: lane flops are not cleared on flush or on completion. The count makes stale lane contents irrelevant.
- Output stability: while word_valid_o=1 && word_ready_i=0, word_o must not change.

## Timing
- Reset values:
  - word_valid_o = 0, word_o = 0, count_o = 0, all lane flops = 0.
  - bit_ready_o = 1 while in reset and after reset release.
- Latency: word_valid_o rises one edge after the completing bit is accepted.
- Throughput: with bit_valid_i and word_ready_i held high, one word every WIDTH cycles, with no bubbles.
- Simultaneous completion, output transfer and flush: flush wins. No completion occurs, but the transfer still clears word_valid_o.
- Reset mid-word or mid-hold: all state returns to reset values immediately. A pending word is lost, and no partial word survives.
- count_o shows the registered count, not the next value.

## Test plan
- Single word, LSB-first (MSB_FIRST=0, WIDTH=4):
  - Stimulus: bits 1,0,1,1 on consecutive cycles, word_ready_i=1.
  - Required: word_o=4'b1101 and word_valid_o=1 for exactly one cycle, one edge after the 4th bit.
- Single word, MSB-first (MSB_FIRST=1):
  - Stimulus: the same stream 1,0,1,1.
  - Required: word_o=4'b1011.
- Back-pressure:
  - Stimulus: word_ready_i=0, stream 8 bits (1,1,1,1, then 0,1,0,1).
  - Required: the first word 4'hF is held stable. Bits 5–7 are accepted and count_o reaches 3. bit_ready_o=0 on the 8th bit.
  - Stimulus: raise word_ready_i.
  - Required: the 8th bit is accepted that cycle; 4'hF transfers and 4'hA appears on the next edge.
- Continuous stream:
  - Stimulus: 16 bits back-to-back, word_ready_i=1.
  - Required: 4 words, with word_valid_o asserted every 4th cycle, and bit_ready_o never low.
- Flush:
  - Stimulus: 2 bits, then flush_i together with a valid bit, then bits 0,1,1,0.
  - Required: the flushed-cycle bit is dropped, count_o=0 after the flush, and the output word is 4'b0110.
- Reset mid-operation:
  - Stimulus: assert rst_ni=0 with count_o=2 and word_valid_o=1.
  - Required: word_valid_o=0, count_o=0 and word_o=0 immediately, without waiting for a clock edge. After release, the next 4 bits form a clean word.
